// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and a parity helper.
// The transmitter uses it now; the future receiver block will reuse it.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Narrower words are zero-extended by the caller; the extra zeros do not change the parity.
  function automatic logic calc_parity(input logic [8:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake and line/status signals of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_out;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_out,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_out,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic tx_clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);

  logic [TIMER_W-1:0] timer_q;

  assign bit_end_o = (timer_q == LAST_TICK);

  // Wrapping at bit_end also restarts the timer on every state change.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (clr_i || bit_end_o) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches one word per valid/ready handshake and sends it LSB-first
// framed by a start bit, optional parity bit and one or two stop bits.
//
//   state     | meaning
//   ST_IDLE   | line high, ready for a word
//   ST_START  | start bit (line low)
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | latched parity bit
//   ST_STOP   | stop bit(s); ready in the final clock for back-to-back frames
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           tx_clk,
  input  logic           rst,
  uart_tx_frame_if.slave tx_if
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam bit   HAS_PARITY = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam logic LAST_STOP  = (STOP_BITS == 2);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  stop_cnt_q;
  logic                  parity_q;
  logic                  tx_out_q;
  logic                  busy_q;
  logic                  done_q;

  logic bit_end;
  logic ready;
  logic accept;
  logic tick_clr;
  logic parity_d;

  assign ready    = (state_q == ST_IDLE) ||
                    ((state_q == ST_STOP) && bit_end && (stop_cnt_q == LAST_STOP));
  assign accept   = tx_if.tx_valid && ready;
  assign tick_clr = (state_q == ST_IDLE) || accept;
  assign parity_d = calc_parity(9'(tx_if.tx_data), PARITY);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .tx_clk   (tx_clk),
    .rst      (rst),
    .clr_i    (tick_clr),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q    <= ST_START;
        shift_q    <= tx_if.tx_data;
        parity_q   <= parity_d;
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
        tx_out_q   <= 1'b0;
        busy_q     <= 1'b1;
        // Accepting in the last stop clock still completes the previous frame.
        if (state_q == ST_STOP) begin
          done_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_START: begin
            if (bit_end) begin
              state_q   <= ST_DATA;
              tx_out_q  <= shift_q[0];
              bit_idx_q <= '0;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
              if (bit_idx_q == LAST_IDX) begin
                if (HAS_PARITY) begin
                  state_q  <= ST_PARITY;
                  tx_out_q <= parity_q;
                end else begin
                  state_q    <= ST_STOP;
                  tx_out_q   <= 1'b1;
                  stop_cnt_q <= 1'b0;
                end
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
                tx_out_q  <= shift_q[1];
              end
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state_q    <= ST_STOP;
              tx_out_q   <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
          end
          ST_STOP: begin
            if (bit_end) begin
              if (stop_cnt_q == LAST_STOP) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                stop_cnt_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_if.tx_ready = ready;
  assign tx_if.tx_out   = tx_out_q;
  assign tx_if.tx_busy  = busy_q;
  assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations, accepted words are queued
// with their accept cycle and per-DUT line monitors decode and compare every frame.
module tb_uart_tx_frame;

  typedef struct {
    logic [8:0] data;
    int         cyc;
  } exp_t;

  localparam int DW [4] = '{8, 8, 8, 5};
  localparam int PM [4] = '{2, 1, 0, 0};
  localparam int SB [4] = '{1, 2, 2, 1};
  localparam int CP [4] = '{4, 2, 1, 3};

  logic tx_clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic       valid_d [4];
  logic [8:0] data_d  [4];
  logic       out_a   [4];
  logic       done_a  [4];
  logic       busy_a  [4];
  logic       ready_a [4];
  exp_t       exp_q   [4][$];

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  initial cyc = 0;
  always @(posedge tx_clk) cyc = cyc + 1;

  uart_tx_frame_if #(.DATA_WIDTH(8)) if0 ();
  uart_tx_frame_if #(.DATA_WIDTH(8)) if1 ();
  uart_tx_frame_if #(.DATA_WIDTH(8)) if2 ();
  uart_tx_frame_if #(.DATA_WIDTH(5)) if3 ();

  uart_tx_frame #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4))
    u_dut0 (.tx_clk(tx_clk), .rst(rst), .tx_if(if0));
  uart_tx_frame #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(2))
    u_dut1 (.tx_clk(tx_clk), .rst(rst), .tx_if(if1));
  uart_tx_frame #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(1))
    u_dut2 (.tx_clk(tx_clk), .rst(rst), .tx_if(if2));
  uart_tx_frame #(.DATA_WIDTH(5), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(3))
    u_dut3 (.tx_clk(tx_clk), .rst(rst), .tx_if(if3));

  assign if0.tx_valid = valid_d[0];
  assign if1.tx_valid = valid_d[1];
  assign if2.tx_valid = valid_d[2];
  assign if3.tx_valid = valid_d[3];
  assign if0.tx_data  = data_d[0][7:0];
  assign if1.tx_data  = data_d[1][7:0];
  assign if2.tx_data  = data_d[2][7:0];
  assign if3.tx_data  = data_d[3][4:0];

  assign out_a[0] = if0.tx_out;   assign out_a[1] = if1.tx_out;
  assign out_a[2] = if2.tx_out;   assign out_a[3] = if3.tx_out;
  assign done_a[0] = if0.tx_done; assign done_a[1] = if1.tx_done;
  assign done_a[2] = if2.tx_done; assign done_a[3] = if3.tx_done;
  assign busy_a[0] = if0.tx_busy; assign busy_a[1] = if1.tx_busy;
  assign busy_a[2] = if2.tx_busy; assign busy_a[3] = if3.tx_busy;
  assign ready_a[0] = if0.tx_ready; assign ready_a[1] = if1.tx_ready;
  assign ready_a[2] = if2.tx_ready; assign ready_a[3] = if3.tx_ready;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] expv);
    n_vec = n_vec + 1;
    if (act !== expv) begin
      n_err = n_err + 1;
      $display("FAIL %s dut%0d @cycle %0d: got %0h, expected %0h", name, id, cyc, act, expv);
    end
  endtask

  function automatic int nbits(input int id);
    return 1 + DW[id] + (((PM[id] == 1) || (PM[id] == 2)) ? 1 : 0) + SB[id];
  endfunction

  // Expected line, one bit per bit period: start, data LSB-first, parity, stops.
  function automatic logic [15:0] ref_line(input int id, input logic [8:0] d);
    logic [15:0] b;
    int ones;
    b = 16'((32'h1 << nbits(id)) - 1);
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DW[id]; i++) begin
      b[1 + i] = d[i];
      ones = ones + int'(d[i]);
    end
    if (PM[id] == 1) b[1 + DW[id]] = ((ones % 2) == 0);
    else if (PM[id] == 2) b[1 + DW[id]] = ((ones % 2) == 1);
    return b;
  endfunction

  // Accepts are recorded the half-cycle before the edge that takes them.
  always @(negedge tx_clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_d[i] === 1'b1 && ready_a[i] === 1'b1) begin
          exp_q[i].push_back('{data: data_d[i] & 9'((32'h1 << DW[i]) - 1), cyc: cyc + 1});
        end
      end
    end
  end

  task automatic mon(input int id);
    int c, f, k, p;
    exp_t e;
    logic [15:0] act, expv;
    bit glitch, bad, abort, have, rdy, b2b, got;
    c = CP[id];
    f = nbits(id) * c;
    have = 1'b0;
    forever begin
      if (!have) @(negedge tx_clk);
      have = 1'b0;
      if (rst || out_a[id] !== 1'b0) continue;
      k = cyc;
      got = (exp_q[id].size() > 0);
      if (got) begin
        e = exp_q[id].pop_front();
        chk("accept_to_start", id, k, e.cyc);
      end else begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_start dut%0d: start bit at cycle %0d, expected no frame", id, k);
        e = '{data: 9'h0, cyc: k};
      end
      expv = ref_line(id, e.data);
      act = '0; glitch = 1'b0; bad = 1'b0; abort = 1'b0; rdy = 1'b0;
      for (int j = 0; j < f; j++) begin
        if (j > 0) @(negedge tx_clk);
        if (rst) begin
          abort = 1'b1;
          break;
        end
        p = j / c;
        if ((j % c) == 0) act[p] = out_a[id];
        else if (out_a[id] !== act[p]) glitch = 1'b1;
        if (busy_a[id] !== 1'b1) bad = 1'b1;
        if (j > 0 && done_a[id] !== 1'b0) bad = 1'b1;
        if (j < f - 1 && ready_a[id] !== 1'b0) bad = 1'b1;
        if (j == f - 1) rdy = ready_a[id];
      end
      if (abort) begin
        int w;
        w = 0;
        while (rst && w < 1000) begin
          @(negedge tx_clk);
          w++;
        end
        continue;
      end
      chk("line_bits", id, act, expv);
      chk("bit_hold_stable", id, glitch, 0);
      chk("busy_done_ready_in_frame", id, bad, 0);
      chk("ready_last_cycle", id, rdy, 1);
      @(negedge tx_clk);
      if (rst) continue;
      chk("done_pulse", id, done_a[id], 1);
      b2b = (exp_q[id].size() > 0) && (exp_q[id][0].cyc == cyc);
      chk("busy_after_frame", id, busy_a[id], b2b);
      have = 1'b1;
    end
  endtask

  initial begin
    #1;
    fork
      mon(0);
      mon(1);
      mon(2);
      mon(3);
    join_none
  end

  task automatic send(input int id, input logic [8:0] d, input bit hold);
    int n;
    @(posedge tx_clk);
    #1;
    valid_d[id] = 1'b1;
    data_d[id]  = d;
    n = 0;
    @(negedge tx_clk);
    while (ready_a[id] !== 1'b1 && n < 2000) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 2000) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL accept_timeout dut%0d: tx_ready is %b, expected 1", id, ready_a[id]);
    end
    @(posedge tx_clk);
    #1;
    if (!hold) valid_d[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 3000 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
           exp_q[3].size() > 0 || busy_a[0] || busy_a[1] || busy_a[2] || busy_a[3])) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 3000) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL drain_timeout: frames still pending after %0d cycles, expected idle", n);
    end
    repeat (4) @(negedge tx_clk);
  endtask

  task automatic rand_run(input int id);
    repeat (6) begin
      repeat ($urandom_range(0, 3)) @(posedge tx_clk);
      send(id, 9'($urandom), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_d[i] = 1'b0;
      data_d[i]  = '0;
    end
    repeat (3) @(negedge tx_clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_out", i, out_a[i], 1);
      chk("reset_busy", i, busy_a[i], 0);
      chk("reset_done", i, done_a[i], 0);
      chk("reset_ready", i, ready_a[i], 1);
    end
    rst = 1'b0;

    send(0, 9'h0A5, 1'b0);
    send(1, 9'h007, 1'b0);
    send(1, 9'h003, 1'b0);
    send(2, 9'h000, 1'b1);
    send(2, 9'h0FF, 1'b0);
    send(3, 9'h015, 1'b0);
    drain();

    send(0, 9'h03C, 1'b0);
    repeat (48) begin
      @(posedge tx_clk);
      #1;
      data_d[0] = 9'($urandom);
    end
    drain();

    // Abort during data bit 3 of DUT 0 (cycles accept+16..accept+19).
    send(0, 9'h0C3, 1'b0);
    repeat (16) @(posedge tx_clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_out", 0, out_a[0], 1);
    chk("rst_busy", 0, busy_a[0], 0);
    chk("rst_ready", 0, ready_a[0], 1);
    repeat (2) begin
      @(negedge tx_clk);
      chk("rst_done", 0, done_a[0], 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge tx_clk);
      chk("post_rst_done", 0, done_a[0], 0);
      chk("post_rst_out", 0, out_a[0], 1);
    end
    send(0, 9'h081, 1'b0);
    drain();

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join
    drain();

    for (int i = 0; i < 4; i++) begin
      chk("queue_empty", i, exp_q[i].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
